// File: rtl/apb_tx_fifo_pkg.sv
// Shared widths, command/status bit positions and the stored frame layout for the TX frame buffer.
package apb_tx_pkg;

   localparam int TRANSMIT_W = 12;
   localparam int ID_W       = 8;
   localparam int DATA_W     = 16;
   localparam int FRAMEW     = TRANSMIT_W + ID_W + DATA_W;

   localparam int CMD_FLUSH   = 0;
   localparam int CMD_CLR_OVF = 1;

   localparam int ST_TX_FULL  = 7;
   localparam int ST_TX_EMPTY = 6;

   typedef struct packed {
      logic [TRANSMIT_W-1:0] transmit;
      logic [ID_W-1:0]       id;
      logic [DATA_W-1:0]     data;
   } frame_t;

endpackage

// File: rtl/apb_tx_fifo_if.sv
// Register-block push side, transmitter valid/ready side and status of the TX frame buffer.
interface apb_tx_fifo_if #(parameter int ADDRW = 3);
   import apb_tx_pkg::*;

   logic                  write_enable_tx;
   logic [TRANSMIT_W-1:0] reg_transmit_tx;
   logic [ID_W-1:0]       reg_id_tx;
   logic [DATA_W-1:0]     reg_data_tx;
   logic [7:0]            reg_command_tx;

   logic                  frame_valid_o;
   logic [TRANSMIT_W-1:0] frame_transmit_o;
   logic [ID_W-1:0]       frame_id_o;
   logic [DATA_W-1:0]     frame_data_o;
   logic                  frame_ready_i;

   logic                  tx_full_o;
   logic                  tx_empty_o;
   logic                  tx_overflow_o;
   logic [ADDRW:0]        tx_count_o;

   modport master (
      output write_enable_tx, reg_transmit_tx, reg_id_tx, reg_data_tx, reg_command_tx,
      output frame_ready_i,
      input  frame_valid_o, frame_transmit_o, frame_id_o, frame_data_o,
      input  tx_full_o, tx_empty_o, tx_overflow_o, tx_count_o
   );

   modport slave (
      input  write_enable_tx, reg_transmit_tx, reg_id_tx, reg_data_tx, reg_command_tx,
      input  frame_ready_i,
      output frame_valid_o, frame_transmit_o, frame_id_o, frame_data_o,
      output tx_full_o, tx_empty_o, tx_overflow_o, tx_count_o
   );

endinterface

// File: rtl/apb_tx_fifo_mem.sv
// DEPTH x WIDTH register array: write lands at the clock edge, read is combinational.
// No reset on the storage; contents are only meaningful where the pointers say so.
module sync_fifo_mem #(
   parameter int ADDRW = 3,
   parameter int WIDTH = 36
) (
   input  logic             PCLK,
   input  logic             wr_en,
   input  logic [ADDRW-1:0] wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [ADDRW-1:0] rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [2**ADDRW];

   always_ff @(posedge PCLK) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/apb_tx_fifo.sv
// TX frame buffer: one push per rising edge of write_enable_tx, show-ahead head on valid/ready.
// Push-to-valid is 1 cycle; pushes while full without a same-cycle pop are dropped and flagged.
module apb_tx_fifo
   import apb_tx_pkg::*;
#(
   parameter int ADDRW = 3
) (
   input logic         PCLK,
   input logic         PRESETn,
   apb_tx_fifo_if.slave bus
);

   localparam int             DEPTH    = 2**ADDRW;
   localparam logic [ADDRW:0] FULL_CNT = (ADDRW+1)'(DEPTH);

   logic             we_d;
   logic [ADDRW-1:0] rd_ptr;
   logic [ADDRW-1:0] wr_ptr;
   logic [ADDRW:0]   count;
   logic             ovf;

   logic push, pop, flush, clr_ovf;
   logic full, empty;
   logic wr_ok, rd_ok, drop;
   logic unused_cmd_bits;

   frame_t wr_frame;
   frame_t rd_frame;

   assign push    = bus.write_enable_tx & ~we_d;
   assign flush   = bus.reg_command_tx[CMD_FLUSH];
   assign clr_ovf = bus.reg_command_tx[CMD_CLR_OVF];
   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign pop     = ~empty & bus.frame_ready_i;

   // Flush swallows any push/pop in the same cycle; a pop frees the slot a full push needs.
   assign wr_ok = push & ~flush & (~full | pop);
   assign rd_ok = pop & ~flush;
   assign drop  = push & ~flush & full & ~pop;

   assign unused_cmd_bits = ^bus.reg_command_tx[7:2];

   assign wr_frame = '{transmit: bus.reg_transmit_tx,
                       id:       bus.reg_id_tx,
                       data:     bus.reg_data_tx};

   sync_fifo_mem #(
      .ADDRW (ADDRW),
      .WIDTH (FRAMEW)
   ) u_mem (
      .PCLK    (PCLK),
      .wr_en   (wr_ok),
      .wr_addr (wr_ptr),
      .wr_data (wr_frame),
      .rd_addr (rd_ptr),
      .rd_data (rd_frame)
   );

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         we_d   <= 1'b0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else begin
         we_d <= bus.write_enable_tx;
         if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, rd_ok})
               2'b10:   count <= count + 1'b1;
               2'b01:   count <= count - 1'b1;
               default: count <= count;
            endcase
         end
         // A drop in the same cycle as a clear leaves the flag set.
         if (drop)                ovf <= 1'b1;
         else if (clr_ovf | flush) ovf <= 1'b0;
      end
   end

   assign bus.frame_valid_o    = ~empty;
   assign bus.frame_transmit_o = rd_frame.transmit;
   assign bus.frame_id_o       = rd_frame.id;
   assign bus.frame_data_o     = rd_frame.data;
   assign bus.tx_full_o        = full;
   assign bus.tx_empty_o       = empty;
   assign bus.tx_overflow_o    = ovf;
   assign bus.tx_count_o       = count;

endmodule

// File: tb/tb_apb_tx_fifo.sv
// Scoreboard bench for apb_tx_fifo: frames queued at push, compared as the transmitter pops them.
module tb_apb_tx_fifo;
   import apb_tx_pkg::*;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   apb_tx_fifo_if #(.ADDRW(3)) bus();

   apb_tx_fifo #(.ADDRW(3)) dut (
      .PCLK    (clk),
      .PRESETn (rstn),
      .bus     (bus)
   );

   int     checks = 0;
   int     errors = 0;
   frame_t sb[$];
   frame_t mon_exp;
   frame_t mon_got;

   localparam frame_t FA = '{transmit: 12'h123, id: 8'h45, data: 16'hBEEF};
   localparam frame_t FB = '{transmit: 12'h0AB, id: 8'h01, data: 16'h1234};

   function automatic frame_t mk(input int i);
      frame_t f;
      f.transmit = 12'(12'h300 + i * 7);
      f.id       = 8'(8'h10 + i);
      f.data     = 16'(16'hA000 + i * 16'h0111);
      return f;
   endfunction

   // Transmitter-side monitor: every accepted head must match the oldest expected frame.
   always @(negedge clk) begin
      if (rstn && bus.frame_valid_o === 1'b1 && bus.frame_ready_i === 1'b1
          && bus.reg_command_tx[CMD_FLUSH] !== 1'b1) begin
         mon_got = {bus.frame_transmit_o, bus.frame_id_o, bus.frame_data_o};
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL pop_unexpected: got %h, expected no frame", mon_got);
         end else begin
            mon_exp = sb.pop_front();
            if (mon_got !== mon_exp) begin
               errors++;
               $display("FAIL pop_order: got %h, expected %h", mon_got, mon_exp);
            end
         end
      end
   end

   task automatic idle_inputs();
      bus.write_enable_tx = 1'b0;
      bus.reg_transmit_tx = '0;
      bus.reg_id_tx       = '0;
      bus.reg_data_tx     = '0;
      bus.reg_command_tx  = '0;
      bus.frame_ready_i   = 1'b0;
   endtask

   task automatic apply_reset();
      rstn = 1'b0;
      idle_inputs();
      sb.delete();
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
   endtask

   task automatic set_fields(input frame_t f);
      bus.reg_transmit_tx = f.transmit;
      bus.reg_id_tx       = f.id;
      bus.reg_data_tx     = f.data;
   endtask

   task automatic push_frame(input frame_t f, input bit accepted);
      @(posedge clk); #1;
      set_fields(f);
      bus.write_enable_tx = 1'b1;
      if (accepted) sb.push_back(f);
      @(posedge clk); #1;
      bus.write_enable_tx = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      bus.frame_ready_i = 1'b1;
      while (bus.frame_valid_o === 1'b1 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      bus.frame_ready_i = 1'b0;
      checks++;
      if (bus.frame_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL drain_timeout: valid=%b after %0d cycles, expected 0", bus.frame_valid_o, n);
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain_leftover: %0d frames never popped, expected 0", sb.size());
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      idle_inputs();
      #2;
      checks++;
      if ({bus.frame_valid_o, bus.tx_empty_o, bus.tx_full_o, bus.tx_overflow_o} !== 4'b0100) begin
         errors++;
         $display("FAIL reset_flags: valid/empty/full/ovf=%b, expected 0100",
                  {bus.frame_valid_o, bus.tx_empty_o, bus.tx_full_o, bus.tx_overflow_o});
      end
      checks++;
      if (bus.tx_count_o !== 4'd0) begin
         errors++;
         $display("FAIL reset_count: got %0d, expected 0", bus.tx_count_o);
      end
      apply_reset();
   endtask

   task automatic test_basic();
      push_frame(FA, 1'b1);
      push_frame(FB, 1'b1);
      @(negedge clk);
      checks++;
      if (bus.tx_count_o !== 4'd2) begin
         errors++;
         $display("FAIL basic_count: got %0d, expected 2", bus.tx_count_o);
      end
      checks++;
      if (bus.frame_valid_o !== 1'b1 ||
          {bus.frame_transmit_o, bus.frame_id_o, bus.frame_data_o} !== FA) begin
         errors++;
         $display("FAIL basic_head: valid=%b head=%h, expected 1 %h", bus.frame_valid_o,
                  {bus.frame_transmit_o, bus.frame_id_o, bus.frame_data_o}, FA);
      end
      @(posedge clk); #1;
      bus.frame_ready_i = 1'b1;
      repeat (2) @(posedge clk);
      #1 bus.frame_ready_i = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.tx_empty_o !== 1'b1 || bus.frame_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL basic_empty: empty=%b valid=%b, expected 1 0", bus.tx_empty_o, bus.frame_valid_o);
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL basic_popped: %0d frames left, expected 0", sb.size());
      end
   endtask

   task automatic test_level_hold();
      @(posedge clk); #1;
      set_fields(mk(40));
      sb.push_back(mk(40));
      bus.write_enable_tx = 1'b1;
      repeat (3) @(posedge clk);
      #1 bus.write_enable_tx = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.tx_count_o !== 4'd1) begin
         errors++;
         $display("FAIL level_hold_count: got %0d, expected 1", bus.tx_count_o);
      end
      drain();
   endtask

   task automatic test_overflow();
      apply_reset();
      for (int i = 0; i < 8; i++) push_frame(mk(i), 1'b1);
      @(negedge clk);
      checks++;
      if ({bus.tx_full_o, bus.tx_empty_o, bus.tx_count_o} !== {1'b1, 1'b0, 4'd8}) begin
         errors++;
         $display("FAIL full_state: full=%b empty=%b count=%0d, expected 1 0 8",
                  bus.tx_full_o, bus.tx_empty_o, bus.tx_count_o);
      end
      push_frame(mk(99), 1'b0);
      @(negedge clk);
      checks++;
      if (bus.tx_overflow_o !== 1'b1 || bus.tx_count_o !== 4'd8) begin
         errors++;
         $display("FAIL overflow_set: ovf=%b count=%0d, expected 1 8", bus.tx_overflow_o, bus.tx_count_o);
      end
      @(posedge clk); #1 bus.reg_command_tx = 8'h02;
      @(posedge clk); #1 bus.reg_command_tx = 8'h00;
      @(negedge clk);
      checks++;
      if (bus.tx_overflow_o !== 1'b0) begin
         errors++;
         $display("FAIL overflow_clear: got %b, expected 0", bus.tx_overflow_o);
      end
      // Dropped push and clear together: the set must win.
      @(posedge clk); #1;
      set_fields(mk(98));
      bus.write_enable_tx = 1'b1;
      bus.reg_command_tx  = 8'h02;
      @(posedge clk); #1;
      bus.write_enable_tx = 1'b0;
      bus.reg_command_tx  = 8'h00;
      @(negedge clk);
      checks++;
      if (bus.tx_overflow_o !== 1'b1) begin
         errors++;
         $display("FAIL overflow_set_wins: got %b, expected 1", bus.tx_overflow_o);
      end
      @(posedge clk); #1 bus.reg_command_tx = 8'h02;
      @(posedge clk); #1 bus.reg_command_tx = 8'h00;
   endtask

   task automatic test_full_push_pop();
      @(posedge clk); #1;
      set_fields(mk(20));
      sb.push_back(mk(20));
      bus.write_enable_tx = 1'b1;
      bus.frame_ready_i   = 1'b1;
      @(posedge clk); #1;
      bus.write_enable_tx = 1'b0;
      bus.frame_ready_i   = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.tx_count_o !== 4'd8 || bus.tx_overflow_o !== 1'b0) begin
         errors++;
         $display("FAIL full_push_pop: count=%0d ovf=%b, expected 8 0", bus.tx_count_o, bus.tx_overflow_o);
      end
      checks++;
      if (dut.wr_ptr !== 3'd1) begin
         errors++;
         $display("FAIL wr_ptr_wrap: got %0d, expected 1", dut.wr_ptr);
      end
      drain();
   endtask

   task automatic test_flush();
      for (int i = 0; i < 5; i++) push_frame(mk(50 + i), 1'b1);
      @(negedge clk);
      checks++;
      if (bus.tx_count_o !== 4'd5) begin
         errors++;
         $display("FAIL flush_preload: got %0d, expected 5", bus.tx_count_o);
      end
      @(posedge clk); #1;
      set_fields(mk(77));
      bus.write_enable_tx = 1'b1;
      bus.reg_command_tx  = 8'h01;
      @(posedge clk); #1;
      bus.write_enable_tx = 1'b0;
      bus.reg_command_tx  = 8'h00;
      sb.delete();
      @(negedge clk);
      checks++;
      if ({bus.tx_count_o, bus.tx_empty_o, bus.frame_valid_o} !== {4'd0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL flush_state: count=%0d empty=%b valid=%b, expected 0 1 0",
                  bus.tx_count_o, bus.tx_empty_o, bus.frame_valid_o);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (bus.frame_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL flush_push_leak: valid=%b, expected 0", bus.frame_valid_o);
      end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 3; i++) push_frame(mk(60 + i), 1'b1);
      @(negedge clk);
      checks++;
      if (bus.tx_count_o !== 4'd3) begin
         errors++;
         $display("FAIL areset_preload: got %0d, expected 3", bus.tx_count_o);
      end
      #2 rstn = 1'b0;
      #1;
      checks++;
      if ({bus.tx_count_o, bus.tx_empty_o, bus.tx_overflow_o, bus.frame_valid_o} !==
          {4'd0, 1'b1, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL areset_immediate: count=%0d empty=%b ovf=%b valid=%b, expected 0 1 0 0",
                  bus.tx_count_o, bus.tx_empty_o, bus.tx_overflow_o, bus.frame_valid_o);
      end
      sb.delete();
      @(posedge clk); #1 rstn = 1'b1;
      push_frame(mk(70), 1'b1);
      drain();
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_basic();
      test_level_hold();
      test_overflow();
      test_full_push_pop();
      test_flush();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/apb_tx_fifo.md
# apb_tx_fifo

Frame buffer between the APB register block and the frame transmitter. Captures one TX frame (transmit control, ID, data) on each rising edge of `write_enable_tx`, stores up to `DEPTH` frames, and presents the oldest frame to the transmitter over a valid/ready handshake. It also drives the TX full/empty status bits that the register block uses to gate writes to the transmit register.

## Interface
- `ADDRW`, 3: pointer width; `DEPTH` = 2**`ADDRW` entries.
- `FRAMEW`, 36: stored frame width = 12 (transmit) + 8 (ID) + 16 (data); fixed, not overridable.
- Reset is `PRESETn`: asynchronous, active-low. Clock is `PCLK`.
- `PCLK` in 1: clock.
- `PRESETn` in 1: asynchronous active-low reset.
- `write_enable_tx` in 1: push request from the register block; level signal, edge-detected here.
- `reg_transmit_tx` in 12: transmit control word to enqueue.
- `reg_id_tx` in 8: frame ID to enqueue.
- `reg_data_tx` in 16: frame data to enqueue.
- `reg_command_tx` in 8: bit0 = flush (level), bit1 = clear overflow (level); other bits are ignored.
- `frame_valid_o` out 1: head entry available.
- `frame_transmit_o` out 12, `frame_id_o` out 8, `frame_data_o` out 16: head entry fields.
- `frame_ready_i` in 1: transmitter accepts the head entry.
- `tx_full_o` out 1: count == `DEPTH`; feeds status bit 7.
- `tx_empty_o` out 1: count == 0; feeds status bit 6.
- `tx_overflow_o` out 1: sticky flag, set when a push is dropped.
- `tx_count_o` out `ADDRW`+1: current occupancy.

## Operation
- Push detect: `we_d` is registered `write_enable_tx`. `push` = `write_enable_tx & ~we_d`. One push per APB write to address 2, even when the enable stays high across back-to-back transfers.
- The input fields are sampled in the same cycle that `push` is high. The register block updates them on the same edge that raises `write_enable_tx`.
- `pop` = `frame_valid_o & frame_ready_i`.
- `frame_valid_o` = `~tx_empty_o`. The head fields are read combinationally from `mem[rd_ptr]` (show-ahead). The head fields hold stable while valid is high and ready is low.
- Pointers are `ADDRW` bits and wrap modulo `DEPTH`. Count is `ADDRW`+1 bits.
- Priority within one cycle:
  - Flush: `rd_ptr`, `wr_ptr` and count go to 0. Any push or pop in that cycle is ignored. Memory contents are not cleared.
  - Otherwise, push and pop both act. A push while full is accepted if a pop occurs in the same cycle; count is unchanged.
  - A push while full with no pop is dropped. Pointers and count are unchanged, and `tx_overflow_o` is set.
  - A push while empty writes the entry. It becomes visible the next cycle; there is no bypass.
- `tx_overflow_o` clears on `reg_command_tx[1]` or on a flush. If a set and a clear occur in the same cycle, the set wins.
- `tx_full_o`, `tx_empty_o` and `tx_count_o` are registered or derived from the registered count. They must never both be 1 at once.

## Timing
- Reset values: `we_d` = 0, pointers = 0, count = 0, `tx_empty_o` = 1, `tx_full_o` = 0, `tx_overflow_o` = 0, `frame_valid_o` = 0. Head fields are don't-care while not valid; the memory is not reset.
- Push-to-valid latency: 1 cycle after the push edge.
- Pop takes effect at the edge where valid and ready are both high. The next entry, if any, is presented in the following cycle.
- Full/empty/count update at the same edge as the push or pop that changes them.
- Reset mid-operation: all state returns to reset values immediately and asynchronously. A reset asserted while `write_enable_tx` is high clears `we_d`. If `write_enable_tx` is still high after reset release, a push occurs. The register block also resets, so this does not arise in practice.

## Structure
- A shared package `apb_tx_pkg` holds:
  - the field widths (12/8/16) and `FRAMEW`;
  - command bit indices `CMD_FLUSH` = 0 and `CMD_CLR_OVF` = 1;
  - status bit indices `ST_TX_FULL` = 7 and `ST_TX_EMPTY` = 6.
- Natural sub-module: `sync_fifo_mem`, a `DEPTH` x `FRAMEW` register array with a synchronous write port and a combinational read port. Edge detect, pointers, count and flags live in `apb_tx_fifo`.

## Test plan
- Reset, then push frames A(0x123, 0x45, 0xBEEF) and B(0x0AB, 0x01, 0x1234) with ready low. Expect count = 2, head = A. Raise ready for 2 cycles: A, then B are popped, then empty = 1 and valid = 0.
- Hold `write_enable_tx` high for 3 cycles. Expect exactly one push and count = 1.
- Push 8 frames. Expect full = 1 and count = 8. A 9th push with ready low is dropped and overflow = 1. Pulse command bit1 and expect overflow = 0.
- With the FIFO full, apply a push and a pop in the same cycle. Expect count to stay 8, `wr_ptr` to wrap to 1 and overflow to stay 0. The new frame emerges last.
- Load 5 frames and apply flush (command = 0x01) together with a push. Expect count = 0, empty = 1 and valid = 0 next cycle, and no entry from that push.
- Assert `PRESETn` low mid-stream with count = 3. Expect count = 0, empty = 1, overflow = 0 and valid = 0 immediately, without waiting for a clock edge.
